// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared constants, FSM state type and operand helper for the FPU issue controller.
package fpu_pkg;

    localparam logic [6:0] FUNCT7_ADD = 7'b0100000;
    localparam logic [6:0] FUNCT7_SUB = 7'b0100100;
    localparam logic [6:0] FUNCT7_MUL = 7'b0000010;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;
    localparam logic [2:0] RM_DYN = 3'b111;

    localparam int FLAG_NX = 0;
    localparam int FLAG_UF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_NV = 4;

    localparam logic [31:0] CANON_NAN = 32'h7FC00000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Subnormal inputs collapse to a zero of the same sign.
    function automatic logic [31:0] flush_subnormal(input logic [31:0] x);
        if (x[30:23] == 8'd0 && x[22:0] != 23'd0)
            return {x[31], 31'd0};
        return x;
    endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Request/response handshake bundle between the issue stage and the FPU sequencer.
interface fpu_issue_ctrl_if #(
    parameter int TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_op1;
    logic [31:0]      req_op2;
    logic [2:0]       req_frm;
    logic [6:0]       req_funct7;
    logic [TAG_W-1:0] req_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic [4:0]       rsp_flags;
    logic             rsp_illegal;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output req_valid, req_op1, req_op2, req_frm, req_funct7, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_illegal, rsp_tag
    );

    modport slave (
        input  req_valid, req_op1, req_op2, req_frm, req_funct7, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_illegal, rsp_tag
    );
endinterface

// File: rtl/fpu_req_decode.sv
// Request decode: rounding-mode resolution, encoding legality, optional flush-to-zero
// of subnormal operands (enabled by FPU_FTZ_EN).
module fpu_req_decode
    import fpu_pkg::*;
(
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [2:0]  frm,
    input  logic [6:0]  funct7,
    input  logic [2:0]  csr_frm,
    output logic [2:0]  rm,
    output logic        legal,
    output logic [31:0] op1_eff,
    output logic [31:0] op2_eff
);

    always_comb begin
        rm = (frm == RM_DYN) ? csr_frm : frm;
        legal = (funct7 == FUNCT7_ADD || funct7 == FUNCT7_SUB || funct7 == FUNCT7_MUL)
                && (rm <= RM_RMM);
`ifdef FPU_FTZ_EN
        op1_eff = flush_subnormal(op1);
        op2_eff = flush_subnormal(op2);
`else
        op1_eff = op1;
        op2_eff = op2;
`endif
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FPU issue sequencer: accepts one request, holds FPU operands for LATENCY cycles, buffers
// the response until consumed and accumulates sticky fflags. Optional FPU_FTZ_EN flushes subnormals.
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int TAG_W   = 5
) (
    input  logic          clk,
    input  logic          nrst,
    fpu_issue_ctrl_if.slave bus,
    input  logic [2:0]    csr_frm,
    output logic [31:0]   fpu_op1,
    output logic [31:0]   fpu_op2,
    output logic [2:0]    fpu_frm,
    output logic [6:0]    fpu_funct7,
    input  logic [31:0]   fpu_result,
    input  logic [4:0]    fpu_flags,
    output logic [4:0]    fflags,
    input  logic          fflags_clr
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [TAG_W-1:0] op_tag;
    logic [31:0]      rsp_result_q;
    logic [4:0]       rsp_flags_q;
    logic             rsp_illegal_q;
    logic [TAG_W-1:0] rsp_tag_q;
    logic             req_ready, rsp_valid, accept, capture;

    logic [2:0]  dec_rm;
    logic        dec_legal;
    logic [31:0] dec_op1, dec_op2;

    fpu_req_decode u_decode (
        .op1     (bus.req_op1),
        .op2     (bus.req_op2),
        .frm     (bus.req_frm),
        .funct7  (bus.req_funct7),
        .csr_frm (csr_frm),
        .rm      (dec_rm),
        .legal   (dec_legal),
        .op1_eff (dec_op1),
        .op2_eff (dec_op2)
    );

    always_ff @(posedge clk) begin
        if (!nrst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)        state_nxt = dec_legal ? ST_BUSY : ST_DONE;
            ST_BUSY: if (capture)       state_nxt = ST_DONE;
            ST_DONE: if (bus.rsp_ready) state_nxt = ST_IDLE;
            default:                    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == ST_IDLE);
        rsp_valid = (state == ST_DONE);
        accept    = bus.req_valid && req_ready;
        capture   = (state == ST_BUSY) && (cnt == '0);
    end

    // Operand registers drive the FPU directly; they only change on a legal accept.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt           <= '0;
            fpu_op1       <= '0;
            fpu_op2       <= '0;
            fpu_frm       <= '0;
            fpu_funct7    <= '0;
            op_tag        <= '0;
            rsp_result_q  <= '0;
            rsp_flags_q   <= '0;
            rsp_illegal_q <= 1'b0;
            rsp_tag_q     <= '0;
            fflags        <= '0;
        end else begin
            if (accept && dec_legal) begin
                fpu_op1    <= dec_op1;
                fpu_op2    <= dec_op2;
                fpu_frm    <= dec_rm;
                fpu_funct7 <= bus.req_funct7;
                op_tag     <= bus.req_tag;
                cnt        <= CNT_W'(LATENCY - 1);
            end else if (state == ST_BUSY && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end

            if (accept && !dec_legal) begin
                rsp_result_q  <= CANON_NAN;
                rsp_flags_q   <= '0;
                rsp_illegal_q <= 1'b1;
                rsp_tag_q     <= bus.req_tag;
            end else if (capture) begin
                rsp_result_q  <= fpu_result;
                rsp_flags_q   <= fpu_flags;
                rsp_illegal_q <= 1'b0;
                rsp_tag_q     <= op_tag;
            end

            // A clear coinciding with a capture keeps only the new flags.
            fflags <= (fflags_clr ? 5'd0 : fflags) | (capture ? fpu_flags : 5'd0);
        end
    end

    assign bus.req_ready   = req_ready;
    assign bus.rsp_valid   = rsp_valid;
    assign bus.rsp_result  = rsp_result_q;
    assign bus.rsp_flags   = rsp_flags_q;
    assign bus.rsp_illegal = rsp_illegal_q;
    assign bus.rsp_tag     = rsp_tag_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: table vectors, hand sequences and random transactions against
// a transaction-level model; a combinational stand-in plays the FPU.
module tb_fpu_issue_ctrl;
    import fpu_pkg::*;

    localparam int LAT = 2;
    localparam int TW  = 5;

    logic        clk = 1'b0;
    logic        nrst;
    logic [2:0]  csr_frm;
    logic [31:0] fpu_op1, fpu_op2, fpu_result;
    logic [2:0]  fpu_frm;
    logic [6:0]  fpu_funct7;
    logic [4:0]  fpu_flags, fflags;
    logic        fflags_clr;

    int n_cmp = 0;
    int n_bad = 0;

    logic [4:0]  fm;
    logic [31:0] lop1, lop2;
    logic [2:0]  lrm;
    logic [6:0]  lf7;

    typedef struct {
        logic [31:0] op1, op2;
        logic [2:0]  frm, csr;
        logic [6:0]  f7;
        logic [TW-1:0] tag;
        int          hold;
        bit          clr;
        bit          exp_illegal;
        logic [2:0]  exp_rm;
    } vec_t;

    fpu_issue_ctrl_if #(.TAG_W(TW)) bus ();

    fpu_issue_ctrl #(.LATENCY(LAT), .TAG_W(TW)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .bus        (bus),
        .csr_frm    (csr_frm),
        .fpu_op1    (fpu_op1),
        .fpu_op2    (fpu_op2),
        .fpu_frm    (fpu_frm),
        .fpu_funct7 (fpu_funct7),
        .fpu_result (fpu_result),
        .fpu_flags  (fpu_flags),
        .fflags     (fflags),
        .fflags_clr (fflags_clr)
    );

    always #5 clk = ~clk;

    // FPU stand-in: any deterministic function of everything the sequencer must hold.
    function automatic logic [36:0] fpu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] rm, input logic [6:0] f7);
        if (f7 == FUNCT7_SUB && a == 32'h411C0000 && b == 32'h3F100000 && rm == 3'b000)
            return {32'h41130000, 5'b00000};
        return {a + (b ^ {f7, rm, 22'd0}), a[4:0] ^ b[4:0]};
    endfunction

    assign {fpu_result, fpu_flags} = fpu_fn(fpu_op1, fpu_op2, fpu_frm, fpu_funct7);

    function automatic logic [2:0] ref_rm(input logic [2:0] frm, input logic [2:0] csr);
        return (frm == 3'b111) ? csr : frm;
    endfunction

    function automatic bit ref_legal(input logic [6:0] f7, input logic [2:0] rm);
        return (f7 inside {7'b0100000, 7'b0100100, 7'b0000010}) && !(rm inside {3'b101, 3'b110, 3'b111});
    endfunction

    function automatic logic [31:0] tb_ftz(input logic [31:0] x);
        return (x[30:23] == 0 && x[22:0] != 0) ? {x[31], 31'd0} : x;
    endfunction

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [2:0] frm,
                                input logic [2:0] csr, input logic [6:0] f7, input logic [TW-1:0] tag,
                                input int hold, input bit clr, input bit ill, input logic [2:0] rm);
        vec_t v;
        v.op1 = a; v.op2 = b; v.frm = frm; v.csr = csr; v.f7 = f7; v.tag = tag;
        v.hold = hold; v.clr = clr; v.exp_illegal = ill; v.exp_rm = rm;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: advance the sticky-flag model on the edge, then compare on the falling edge.
    task automatic cycle(input bit cap, input logic [4:0] f);
        @(posedge clk);
        if (!nrst) fm = 5'd0;
        else       fm = (fflags_clr ? 5'd0 : fm) | (cap ? f : 5'd0);
        @(negedge clk);
        chk("fflags", {59'd0, fflags}, {59'd0, fm});
    endtask

    task automatic run_txn(input vec_t v);
        logic [31:0] e1, e2, eres;
        logic [4:0]  efl;
        logic [36:0] er;
        chk("req_ready_idle", {63'd0, bus.req_ready}, 64'd1);
        e1 = v.op1;
        e2 = v.op2;
`ifdef FPU_FTZ_EN
        e1 = tb_ftz(e1);
        e2 = tb_ftz(e2);
`endif
        er = fpu_fn(e1, e2, v.exp_rm, v.f7);
        if (v.exp_illegal) begin eres = CANON_NAN; efl = 5'd0; end
        else               begin eres = er[36:5];  efl = er[4:0]; end

        bus.req_valid = 1'b1; bus.req_op1 = v.op1; bus.req_op2 = v.op2;
        bus.req_frm = v.frm; bus.req_funct7 = v.f7; bus.req_tag = v.tag; csr_frm = v.csr;
        cycle(1'b0, 5'd0);
        bus.req_valid = 1'b0; bus.req_op1 = $urandom; bus.req_op2 = $urandom;
        bus.req_frm = 3'($urandom); bus.req_funct7 = 7'($urandom); bus.req_tag = TW'($urandom);
        csr_frm = 3'($urandom);

        if (!v.exp_illegal) begin
            lop1 = e1; lop2 = e2; lrm = v.exp_rm; lf7 = v.f7;
            for (int e = 1; e <= LAT; e++) begin
                chk("rsp_valid_busy", {63'd0, bus.rsp_valid}, 64'd0);
                chk("req_ready_busy", {63'd0, bus.req_ready}, 64'd0);
                chk("fpu_op1_hold", {32'd0, fpu_op1}, {32'd0, lop1});
                chk("fpu_op2_hold", {32'd0, fpu_op2}, {32'd0, lop2});
                chk("fpu_frm_hold", {61'd0, fpu_frm}, {61'd0, lrm});
                chk("fpu_funct7_hold", {57'd0, fpu_funct7}, {57'd0, lf7});
                fflags_clr = (e == LAT) && v.clr;
                cycle(e == LAT, efl);
                fflags_clr = 1'b0;
            end
        end

        chk("rsp_valid_done", {63'd0, bus.rsp_valid}, 64'd1);
        chk("rsp_result", {32'd0, bus.rsp_result}, {32'd0, eres});
        chk("rsp_flags", {59'd0, bus.rsp_flags}, {59'd0, efl});
        chk("rsp_illegal", {63'd0, bus.rsp_illegal}, {63'd0, v.exp_illegal});
        chk("rsp_tag", {59'd0, bus.rsp_tag}, {59'd0, v.tag});
        chk("fpu_op1_done", {32'd0, fpu_op1}, {32'd0, lop1});
        chk("fpu_frm_done", {61'd0, fpu_frm}, {61'd0, lrm});

        for (int h = 0; h < v.hold; h++) begin
            bus.rsp_ready = 1'b0;
            cycle(1'b0, 5'd0);
            chk("rsp_valid_stall", {63'd0, bus.rsp_valid}, 64'd1);
            chk("rsp_result_stall", {32'd0, bus.rsp_result}, {32'd0, eres});
            chk("rsp_flags_stall", {59'd0, bus.rsp_flags}, {59'd0, efl});
            chk("rsp_tag_stall", {59'd0, bus.rsp_tag}, {59'd0, v.tag});
            chk("req_ready_stall", {63'd0, bus.req_ready}, 64'd0);
        end
        bus.rsp_ready = 1'b1;
        fflags_clr = ($urandom_range(0, 3) == 0);
        cycle(1'b0, 5'd0);
        fflags_clr = 1'b0;
        chk("rsp_valid_release", {63'd0, bus.rsp_valid}, 64'd0);
        chk("req_ready_release", {63'd0, bus.req_ready}, 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        vec_t v;
        fm = 5'd0; lop1 = '0; lop2 = '0; lrm = '0; lf7 = '0;
        nrst = 1'b0; fflags_clr = 1'b0; csr_frm = 3'b000;
        bus.req_valid = 1'b0; bus.req_op1 = '0; bus.req_op2 = '0; bus.req_frm = '0;
        bus.req_funct7 = '0; bus.req_tag = '0; bus.rsp_ready = 1'b1;

        tbl[0] = mk(32'h411C0000, 32'h3F100000, 3'b000, 3'b011, 7'b0100100, 5'd5,  0, 0, 0, 3'b000);
        tbl[1] = mk(32'h40490FDB, 32'h3F800000, 3'b111, 3'b010, 7'b0100000, 5'd9,  5, 0, 0, 3'b010);
        tbl[2] = mk(32'hC0000000, 32'h40400000, 3'b100, 3'b000, 7'b0000010, 5'd17, 1, 0, 0, 3'b100);
        tbl[3] = mk(32'h3F800000, 32'h3F800000, 3'b111, 3'b101, 7'b0100000, 5'd3,  0, 0, 1, 3'b101);
        tbl[4] = mk(32'h3F800000, 32'h40000000, 3'b000, 3'b000, 7'b0000001, 5'd4,  2, 0, 1, 3'b000);
        tbl[5] = mk(32'h12345678, 32'h9ABCDEF0, 3'b101, 3'b000, 7'b0100100, 5'd6,  0, 0, 1, 3'b101);
        tbl[6] = mk(32'h12345678, 32'h9ABCDEF0, 3'b110, 3'b001, 7'b0000010, 5'd7,  0, 0, 1, 3'b110);
        tbl[7] = mk(32'h12345678, 32'h9ABCDEF0, 3'b111, 3'b111, 7'b0100000, 5'd8,  0, 0, 1, 3'b111);
        tbl[8] = mk(32'h7F7FFFFF, 32'h00000003, 3'b011, 3'b110, 7'b0100000, 5'd31, 0, 0, 0, 3'b011);
        tbl[9] = mk(32'h3F800007, 32'h3F800002, 3'b111, 3'b001, 7'b0000010, 5'd0,  0, 1, 0, 3'b001);

        cycle(1'b0, 5'd0);
        cycle(1'b0, 5'd0);
        nrst = 1'b1;
        chk("reset_req_ready", {63'd0, bus.req_ready}, 64'd1);
        chk("reset_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("reset_rsp_illegal", {63'd0, bus.rsp_illegal}, 64'd0);
        chk("reset_fpu_op1", {32'd0, fpu_op1}, 64'd0);
        chk("reset_fpu_frm", {61'd0, fpu_frm}, 64'd0);
        chk("reset_fflags", {59'd0, fflags}, 64'd0);

        for (int i = 0; i < 10; i++) run_txn(tbl[i]);

        // Sticky accumulation, then a clear landing on a capture edge.
        fflags_clr = 1'b1;
        cycle(1'b0, 5'd0);
        fflags_clr = 1'b0;
        run_txn(mk(32'h3F800001, 32'h3F800000, 3'b000, 3'b000, 7'b0100000, 5'd1, 0, 0, 0, 3'b000));
        chk("fflags_first", {59'd0, fflags}, 64'h01);
        run_txn(mk(32'h3F800004, 32'h3F800000, 3'b000, 3'b000, 7'b0100000, 5'd2, 0, 0, 0, 3'b000));
        chk("fflags_accum", {59'd0, fflags}, 64'h05);
        run_txn(mk(32'h3F800004, 32'h3F800000, 3'b000, 3'b000, 7'b0100000, 5'd3, 0, 1, 0, 3'b000));
        chk("fflags_clr_capture", {59'd0, fflags}, 64'h04);

`ifdef FPU_FTZ_EN
        run_txn(mk(32'h00000001, 32'h3F800000, 3'b000, 3'b000, 7'b0100000, 5'd10, 0, 0, 0, 3'b000));
        chk("ftz_pos", {32'd0, fpu_op1}, 64'h0);
        run_txn(mk(32'h80000001, 32'h3F800000, 3'b000, 3'b000, 7'b0100000, 5'd11, 0, 0, 0, 3'b000));
        chk("ftz_neg", {32'd0, fpu_op1}, 64'h80000000);
`endif

        for (int i = 0; i < 40; i++) begin
            v.op1 = $urandom;
            v.op2 = $urandom;
            if ($urandom_range(0, 4) == 0) v.op1 = v.op1 & 32'h807FFFFF;
            case ($urandom_range(0, 3))
                0: v.f7 = FUNCT7_ADD;
                1: v.f7 = FUNCT7_SUB;
                2: v.f7 = FUNCT7_MUL;
                default: v.f7 = 7'($urandom);
            endcase
            v.frm = 3'($urandom);
            v.csr = 3'($urandom);
            v.tag = TW'($urandom);
            v.hold = $urandom_range(0, 3);
            v.clr = ($urandom_range(0, 3) == 0);
            v.exp_rm = ref_rm(v.frm, v.csr);
            v.exp_illegal = !ref_legal(v.f7, v.exp_rm);
            run_txn(v);
        end

        // Reset while an operation is in flight: nothing must come out afterwards.
        bus.req_valid = 1'b1; bus.req_op1 = 32'h40000000; bus.req_op2 = 32'h40000001;
        bus.req_frm = 3'b000; bus.req_funct7 = FUNCT7_MUL; bus.req_tag = 5'd12;
        cycle(1'b0, 5'd0);
        bus.req_valid = 1'b0;
        cycle(1'b0, 5'd0);
        chk("busy_before_reset", {63'd0, bus.req_ready}, 64'd0);
        nrst = 1'b0;
        cycle(1'b0, 5'd0);
        nrst = 1'b1;
        chk("midreset_req_ready", {63'd0, bus.req_ready}, 64'd1);
        chk("midreset_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("midreset_fflags", {59'd0, fflags}, 64'd0);
        chk("midreset_fpu_op1", {32'd0, fpu_op1}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 5'd0);
            chk("no_rsp_after_reset", {63'd0, bus.rsp_valid}, 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
